if_id_hazard: RTL

// - IF/ID pipeline register with a built-in load-use hazard detector; sits between fetch and the ID/EX register.
// - Holds the fetched PC and instruction, and stalls PC and IF/ID for one cycle when the instruction in ID reads a register being loaded by the instruction in EX.
// - Flushes on a taken branch.
// - Drives the bubble request that zeroes the control signals entering ID/EX.
// - Keeps saturating stall and flush counters for performance bring-up.

---
 rtl/legv8_pkg.sv | 50 +++++
 rtl/hazard_detect.sv | 51 +++++
 rtl/if_id_hazard.sv | 112 +++++++++++
 3 files changed

// File: rtl/legv8_pkg.sv
// -----------------------------------------------------------------------------
// legv8_pkg
// Purpose : LEGv8 opcode constants and the source-register selector used by the
//           IF/ID load-use hazard logic.
// Contents: OP_* opcode fields, XZR register index, default counter width,
//           src_sel_e and decode_src() (which source fields an instruction reads).
// -----------------------------------------------------------------------------
package legv8_pkg;

   // 11-bit opcode field, instruction bits [31:21]
   localparam logic [10:0] OP_ADD  = 11'h458;
   localparam logic [10:0] OP_SUB  = 11'h658;
   localparam logic [10:0] OP_AND  = 11'h450;
   localparam logic [10:0] OP_ORR  = 11'h550;
   localparam logic [10:0] OP_LDUR = 11'h7C2;
   localparam logic [10:0] OP_STUR = 11'h7C0;
   // Short opcode fields: CBZ in [31:24], B in [31:26]
   localparam logic [7:0]  OP_CBZ8 = 8'hB4;
   localparam logic [5:0]  OP_B6   = 6'h05;

   localparam logic [4:0]  XZR = 5'd31;

   localparam int unsigned CNT_W_DEFAULT = 16;

   typedef enum logic [2:0] {
      SrcNone,
      SrcRn,
      SrcRt,
      SrcRnRm,
      SrcRnRt
   } src_sel_e;

   // LDUR, I-type and unrecognised opcodes all fall through to "reads Rn".
   function automatic src_sel_e decode_src(input logic [31:0] instr);
      src_sel_e sel;
      sel = SrcRn;
      if (instr[31:26] == OP_B6) begin
         sel = SrcNone;
      end else if (instr[31:24] == OP_CBZ8) begin
         sel = SrcRt;
      end else if (instr[31:21] == OP_ADD || instr[31:21] == OP_SUB ||
                   instr[31:21] == OP_AND || instr[31:21] == OP_ORR) begin
         sel = SrcRnRm;
      end else if (instr[31:21] == OP_STUR) begin
         sel = SrcRnRt;
      end
      return sel;
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Purpose : Combinational load-use detector. Decodes which registers the ID
//           instruction reads and compares them with the load destination in EX.
// Ports   : i_instr          instruction currently in IF/ID
//           i_valid          IF/ID holds a live instruction
//           i_idex_memread   instruction in EX is a load
//           i_idex_write_reg destination register of the instruction in EX
//           o_hazard         load-use hazard present (before branch override)
// -----------------------------------------------------------------------------
module hazard_detect
   import legv8_pkg::*;
(
   input  logic [31:0] i_instr,
   input  logic        i_valid,
   input  logic        i_idex_memread,
   input  logic [4:0]  i_idex_write_reg,
   output logic        o_hazard
);

   src_sel_e w_sel;
   logic     w_rn_hit;
   logic     w_rm_hit;
   logic     w_rt_hit;
   logic     w_match;

   // Shamt / immediate bits never name a register.
   logic     w_unused_instr;
   assign w_unused_instr = ^i_instr[15:10];

   assign w_sel    = decode_src(i_instr);
   assign w_rn_hit = (i_instr[9:5]   == i_idex_write_reg);
   assign w_rm_hit = (i_instr[20:16] == i_idex_write_reg);
   assign w_rt_hit = (i_instr[4:0]   == i_idex_write_reg);

   always_comb begin
      w_match = 1'b0;
      unique case (w_sel)
         SrcNone: w_match = 1'b0;
         SrcRn:   w_match = w_rn_hit;
         SrcRt:   w_match = w_rt_hit;
         SrcRnRm: w_match = w_rn_hit | w_rm_hit;
         SrcRnRt: w_match = w_rn_hit | w_rt_hit;
         default: w_match = w_rn_hit;
      endcase
   end

   // XZR reads as zero, so a load "into" X31 never feeds anything.
   assign o_hazard = i_valid & i_idex_memread & (i_idex_write_reg != XZR) & w_match;

endmodule

// File: rtl/if_id_hazard.sv
// -----------------------------------------------------------------------------
// if_id_hazard
// Purpose : IF/ID pipeline register with load-use stall, branch flush, ID/EX
//           bubble request and saturating stall/flush performance counters.
// Ports   : clock, reset_n       clock / async active-low reset
//           pc_in, instruction_in, fetch_valid    fetch-side inputs
//           idex_memread, idex_write_reg          load info from ID/EX
//           branch_taken        flush request
//           pc_out, instruction_out, valid_out    registered IF/ID contents
//           pc_write            PC update enable (0 while stalling)
//           ctrl_bubble         zero the control signals entering ID/EX
//           stall_count, flush_count              saturating event counters
// -----------------------------------------------------------------------------
module if_id_hazard
   import legv8_pkg::*;
#(
   parameter int unsigned PC_W    = 64,
   parameter int unsigned INSTR_W = 32,  // decode assumes 32; do not change
   parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic [PC_W-1:0]    pc_in,
   input  logic [INSTR_W-1:0] instruction_in,
   input  logic               fetch_valid,
   input  logic               idex_memread,
   input  logic [4:0]         idex_write_reg,
   input  logic               branch_taken,
   output logic [PC_W-1:0]    pc_out,
   output logic [INSTR_W-1:0] instruction_out,
   output logic               valid_out,
   output logic               pc_write,
   output logic               ctrl_bubble,
   output logic [CNT_W-1:0]   stall_count,
   output logic [CNT_W-1:0]   flush_count
);

   logic [PC_W-1:0]    r_pc;
   logic [INSTR_W-1:0] r_instr;
   logic               r_valid;
   logic [CNT_W-1:0]   r_stall_cnt;
   logic [CNT_W-1:0]   r_flush_cnt;

   logic [PC_W-1:0]    w_pc_nxt;
   logic [INSTR_W-1:0] w_instr_nxt;
   logic               w_valid_nxt;
   logic [CNT_W-1:0]   w_stall_cnt_nxt;
   logic [CNT_W-1:0]   w_flush_cnt_nxt;

   logic               w_hazard;
   logic               w_hazard_stall;

   hazard_detect u_hazard_detect (
      .i_instr          (r_instr),
      .i_valid          (r_valid),
      .i_idex_memread   (idex_memread),
      .i_idex_write_reg (idex_write_reg),
      .o_hazard         (w_hazard)
   );

   // A taken branch discards the ID instruction, so its hazard is moot.
   assign w_hazard_stall = w_hazard & ~branch_taken;
   assign pc_write       = ~w_hazard_stall;
   assign ctrl_bubble    = w_hazard_stall | branch_taken | ~r_valid;

   always_comb begin
      w_pc_nxt        = r_pc;
      w_instr_nxt     = r_instr;
      w_valid_nxt     = r_valid;
      w_stall_cnt_nxt = r_stall_cnt;
      w_flush_cnt_nxt = r_flush_cnt;
      if (branch_taken) begin
         w_valid_nxt = 1'b0;
         w_instr_nxt = '0;
         if (r_flush_cnt != '1) begin
            w_flush_cnt_nxt = r_flush_cnt + CNT_W'(1);
         end
      end else if (w_hazard_stall) begin
         // Hold IF/ID; the bubble clears idex_memread so this lasts one cycle.
         if (r_stall_cnt != '1) begin
            w_stall_cnt_nxt = r_stall_cnt + CNT_W'(1);
         end
      end else begin
         w_pc_nxt    = pc_in;
         w_instr_nxt = instruction_in;
         w_valid_nxt = fetch_valid;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_pc        <= '0;
         r_instr     <= '0;
         r_valid     <= 1'b0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         r_pc        <= w_pc_nxt;
         r_instr     <= w_instr_nxt;
         r_valid     <= w_valid_nxt;
         r_stall_cnt <= w_stall_cnt_nxt;
         r_flush_cnt <= w_flush_cnt_nxt;
      end
   end

   assign pc_out          = r_pc;
   assign instruction_out = r_instr;
   assign valid_out       = r_valid;
   assign stall_count     = r_stall_cnt;
   assign flush_count     = r_flush_cnt;

endmodule
